// File: rtl/alu_sched_pkg.sv
// Shared types for the round-robin ALU scheduler: opcode and FSM state encodings.
package alu_sched_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpShl  = 3'b010,
        OpShr  = 3'b011,
        OpAnd  = 3'b100,
        OpOr   = 3'b101,
        OpXnor = 3'b110,
        OpEq   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } sched_state_e;

endpackage

// File: rtl/alu_rr_sched_if.sv
// Request/response bundle for the two requesters of the ALU scheduler.
interface alu_rr_sched_if #(
    parameter int unsigned DW = 8
);
    logic          req0_valid_i;
    logic          req0_ready_o;
    logic [DW-1:0] req0_a_i;
    logic [DW-1:0] req0_b_i;
    logic [2:0]    req0_op_i;
    logic          req1_valid_i;
    logic          req1_ready_o;
    logic [DW-1:0] req1_a_i;
    logic [DW-1:0] req1_b_i;
    logic [2:0]    req1_op_i;
    logic          rsp0_valid_o;
    logic          rsp0_ready_i;
    logic [DW-1:0] rsp0_data_o;
    logic          rsp1_valid_o;
    logic          rsp1_ready_i;
    logic [DW-1:0] rsp1_data_o;

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        output req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        output rsp0_ready_i, rsp1_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o
    );

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_op_i,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_op_i,
        input  rsp0_ready_i, rsp1_ready_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_data_o, rsp1_valid_o, rsp1_data_o
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU shared by both requesters.
module alu_core
    import alu_sched_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  alu_op_e       op_i,
    output logic [DW-1:0] y_o
);
    always_comb begin
        y_o = '0;
        unique case (op_i)
            OpAdd:  y_o = a_i + b_i;
            OpSub:  y_o = a_i - b_i;
            // Shift amounts >= DW already yield zero for logical shifts.
            OpShl:  y_o = a_i << b_i;
            OpShr:  y_o = a_i >> b_i;
            OpAnd:  y_o = a_i & b_i;
            OpOr:   y_o = a_i | b_i;
            OpXnor: y_o = ~(a_i ^ b_i);
            OpEq:   y_o = DW'(a_i == b_i);
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_rr_sched.sv
// Two-requester round-robin scheduler in front of one shared ALU; one operation in flight.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    alu_rr_sched_if.slave    bus,
    output logic             busy_o,
    output logic [CNT_W-1:0] ops_done_o
);
    sched_state_e     state_q;
    logic             prio_q;
    logic             owner_q;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    alu_op_e          op_q;
    logic [DW-1:0]    result_q;
    logic [1:0]       rsp_valid_q;
    logic             busy_q;
    logic [CNT_W-1:0] ops_done_q;
    logic [CNT_W-1:0] ops_done_d;

    logic          any_valid;
    logic          gnt_id;
    logic          grant_en;
    logic          rsp_hs;
    logic [DW-1:0] alu_y;

    always_comb begin
        any_valid  = bus.req0_valid_i | bus.req1_valid_i;
        gnt_id     = (bus.req0_valid_i & bus.req1_valid_i) ? prio_q : bus.req1_valid_i;
        // Gating with rst_ni keeps ready low while reset is held.
        grant_en   = rst_ni & (state_q == StIdle) & any_valid;
        rsp_hs     = (state_q == StResp) & (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i);
        ops_done_d = (&ops_done_q) ? ops_done_q : ops_done_q + CNT_W'(1);
    end

    assign bus.req0_ready_o = grant_en & ~gnt_id;
    assign bus.req1_ready_o = grant_en & gnt_id;
    assign bus.rsp0_valid_o = rsp_valid_q[0];
    assign bus.rsp1_valid_o = rsp_valid_q[1];
    assign bus.rsp0_data_o  = result_q;
    assign bus.rsp1_data_o  = result_q;
    assign busy_o           = busy_q;
    assign ops_done_o       = ops_done_q;

    alu_core #(
        .DW(DW)
    ) u_alu (
        .a_i (a_q),
        .b_i (b_q),
        .op_i(op_q),
        .y_o (alu_y)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OpAdd;
            result_q    <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        owner_q <= gnt_id;
                        prio_q  <= ~gnt_id;
                        a_q     <= gnt_id ? bus.req1_a_i : bus.req0_a_i;
                        b_q     <= gnt_id ? bus.req1_b_i : bus.req0_b_i;
                        op_q    <= alu_op_e'(gnt_id ? bus.req1_op_i : bus.req0_op_i);
                        busy_q  <= 1'b1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q    <= alu_y;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        ops_done_q  <= ops_done_d;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed table, corner sequences, random vs model.
module tb_alu_rr_sched;
    localparam int unsigned DW   = 8;
    localparam int unsigned CntW = 4;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            busy;
    logic [CntW-1:0] ops_done;
    int              n_vec = 0;
    int              n_err = 0;

    alu_rr_sched_if #(.DW(DW)) bus ();

    alu_rr_sched #(
        .DW   (DW),
        .CNT_W(CntW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .ops_done_o(ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        case (op)
            3'd0: return 8'((ai + bi) % 256);
            3'd1: return 8'((ai + 256 - bi) % 256);
            3'd2: return (bi >= 8) ? 8'h00 : 8'((ai << bi) % 256);
            3'd3: return (bi >= 8) ? 8'h00 : 8'(ai >> bi);
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return ~(a ^ b);
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    task automatic drive_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op);
        if (id == 0) begin
            bus.req0_valid_i = v; bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_op_i = op;
        end else begin
            bus.req1_valid_i = v; bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_op_i = op;
        end
    endtask

    task automatic idle_inputs();
        drive_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
        drive_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req0_ready"}, bus.req0_ready_o, 0);
        check({tag, " req1_ready"}, bus.req1_ready_o, 0);
        check({tag, " rsp0_valid"}, bus.rsp0_valid_o, 0);
        check({tag, " rsp1_valid"}, bus.rsp1_valid_o, 0);
        check({tag, " rsp0_data"}, bus.rsp0_data_o, 0);
        check({tag, " rsp1_data"}, bus.rsp1_data_o, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " ops_done"}, ops_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation with immediate response handshake: 3 cycles, rsp 2 cycles after grant.
    task automatic run_vec(input int id, input vec_t v, input string tag);
        @(negedge clk);
        drive_req(id, 1'b1, v.a, v.b, v.op);
        #1;
        check({tag, " grant"}, id ? bus.req1_ready_o : bus.req0_ready_o, 1);
        check({tag, " other grant"}, id ? bus.req0_ready_o : bus.req1_ready_o, 0);
        @(negedge clk);
        drive_req(id, 1'b0, 8'h00, 8'h00, 3'd0);
        #1;
        check({tag, " early rsp"}, id ? bus.rsp1_valid_o : bus.rsp0_valid_o, 0);
        check({tag, " busy exec"}, busy, 1);
        @(negedge clk);
        #1;
        check({tag, " rsp valid"}, id ? bus.rsp1_valid_o : bus.rsp0_valid_o, 1);
        check({tag, " other rsp"}, id ? bus.rsp0_valid_o : bus.rsp1_valid_o, 0);
        check({tag, " data"}, id ? bus.rsp1_data_o : bus.rsp0_data_o, v.y);
        if (id == 0) bus.rsp0_ready_i = 1'b1;
        else bus.rsp1_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
    endtask

    vec_t tbl[15];

    // Random-phase model state: requester queues and an in-flight timeline.
    logic       pend[2];
    logic [7:0] p_a[2];
    logic [7:0] p_b[2];
    logic [2:0] p_op[2];
    logic       rr[2];
    bit         m_busy;
    int         m_owner, m_age, m_prio, m_cnt;
    logic [7:0] m_res;

    initial begin
        tbl[0]  = '{3'b000, 8'h0F, 8'h01, 8'h10};
        tbl[1]  = '{3'b000, 8'hFF, 8'h02, 8'h01};
        tbl[2]  = '{3'b001, 8'h00, 8'h01, 8'hFF};
        tbl[3]  = '{3'b001, 8'h10, 8'h01, 8'h0F};
        tbl[4]  = '{3'b010, 8'h81, 8'h01, 8'h02};
        tbl[5]  = '{3'b010, 8'h01, 8'h07, 8'h80};
        tbl[6]  = '{3'b010, 8'h01, 8'h08, 8'h00};
        tbl[7]  = '{3'b011, 8'h80, 8'h09, 8'h00};
        tbl[8]  = '{3'b011, 8'h80, 8'h07, 8'h01};
        tbl[9]  = '{3'b100, 8'hF0, 8'h3C, 8'h30};
        tbl[10] = '{3'b101, 8'hF0, 8'h0F, 8'hFF};
        tbl[11] = '{3'b110, 8'hF0, 8'h0F, 8'h00};
        tbl[12] = '{3'b110, 8'hA5, 8'hA5, 8'hFF};
        tbl[13] = '{3'b111, 8'h5A, 8'h5A, 8'h01};
        tbl[14] = '{3'b111, 8'h5A, 8'h5B, 8'h00};
        idle_inputs();

        // Directed table, alternating requesters, back-to-back.
        do_reset();
        for (int i = 0; i < 15; i++) run_vec(i % 2, tbl[i], $sformatf("tbl%0d", i));
        @(negedge clk);
        check("tbl ops_done", ops_done, 15);

        // Both valid from reset: grants alternate 0,1,0,1.
        do_reset();
        drive_req(0, 1'b1, 8'h00, 8'h01, 3'b001);
        drive_req(1, 1'b1, 8'h5A, 8'h5A, 3'b111);
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            check($sformatf("rr c%0d ready0", c), bus.req0_ready_o,
                  (c % 3 == 0) && ((c / 3) % 2 == 0));
            check($sformatf("rr c%0d ready1", c), bus.req1_ready_o,
                  (c % 3 == 0) && ((c / 3) % 2 == 1));
            if (c % 3 == 2) begin
                check($sformatf("rr c%0d rsp0", c), bus.rsp0_valid_o, (c / 3) % 2 == 0);
                check($sformatf("rr c%0d rsp1", c), bus.rsp1_valid_o, (c / 3) % 2 == 1);
                check($sformatf("rr c%0d data", c), bus.rsp0_data_o,
                      ((c / 3) % 2 == 0) ? 8'hFF : 8'h01);
            end
        end

        // Response back-pressure: data held, no new grant until the handshake.
        do_reset();
        drive_req(0, 1'b1, 8'h01, 8'h02, 3'b000);
        drive_req(1, 1'b1, 8'h33, 8'h11, 3'b101);
        #1;
        check("bp grant0", bus.req0_ready_o, 1);
        @(negedge clk);
        drive_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("bp rsp0 valid", bus.rsp0_valid_o, 1);
            check("bp rsp0 data", bus.rsp0_data_o, 8'h03);
            check("bp ready0", bus.req0_ready_o, 0);
            check("bp ready1", bus.req1_ready_o, 0);
        end
        bus.rsp0_ready_i = 1'b1;
        drive_req(0, 1'b1, 8'h01, 8'h02, 3'b000);
        @(negedge clk);
        bus.rsp0_ready_i = 1'b0;
        #1;
        check("bp after ready1", bus.req1_ready_o, 1);
        check("bp after ready0", bus.req0_ready_o, 0);
        check("bp after rsp0", bus.rsp0_valid_o, 0);
        check("bp ops_done", ops_done, 1);

        // Reset pulse during EXEC discards the operation.
        do_reset();
        drive_req(0, 1'b1, 8'h0F, 8'h01, 3'b000);
        @(negedge clk);
        idle_inputs();
        bus.rsp0_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid-op reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("discard rsp0", bus.rsp0_valid_o, 0);
            check("discard busy", busy, 0);
            check("discard ops_done", ops_done, 0);
        end
        do_reset();
        drive_req(1, 1'b1, 8'h01, 8'h01, 3'b000);
        #1;
        check("first cycle grant", bus.req1_ready_o, 1);

        // Random traffic against the timeline model.
        do_reset();
        pend[0] = 0; pend[1] = 0;
        m_busy = 0; m_owner = 0; m_age = 0; m_prio = 0; m_cnt = 0; m_res = 0;
        for (int c = 0; c < 300; c++) begin
            int g;
            bit any;
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1;
                    p_a[r]  = 8'($urandom);
                    p_b[r]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12))
                                                          : 8'($urandom);
                    p_op[r] = 3'($urandom);
                end
                rr[r] = ($urandom_range(0, 9) < 7);
                drive_req(r, pend[r], p_a[r], p_b[r], p_op[r]);
            end
            bus.rsp0_ready_i = rr[0];
            bus.rsp1_ready_i = rr[1];
            any = pend[0] || pend[1];
            g = (pend[0] && pend[1]) ? m_prio : (pend[1] ? 1 : 0);
            #1;
            check("rnd ready0", bus.req0_ready_o, !m_busy && any && g == 0);
            check("rnd ready1", bus.req1_ready_o, !m_busy && any && g == 1);
            check("rnd rsp0", bus.rsp0_valid_o, m_busy && m_age >= 2 && m_owner == 0);
            check("rnd rsp1", bus.rsp1_valid_o, m_busy && m_age >= 2 && m_owner == 1);
            check("rnd busy", busy, m_busy);
            check("rnd ops_done", ops_done, m_cnt);
            if (m_busy && m_age >= 2)
                check("rnd data", m_owner ? bus.rsp1_data_o : bus.rsp0_data_o, m_res);
            if (m_busy) begin
                if (m_age >= 2 && rr[m_owner]) begin
                    m_busy = 0;
                    m_cnt = (m_cnt < CntMax) ? m_cnt + 1 : m_cnt;
                end else begin
                    m_age++;
                end
            end else if (any) begin
                m_busy  = 1;
                m_owner = g;
                m_res   = alu_ref(p_op[g], p_a[g], p_b[g]);
                m_age   = 1;
                m_prio  = 1 - g;
                pend[g] = 0;
            end
        end

        // Counter saturation: reach all-ones minus 1, then 3 more operations.
        do_reset();
        for (int i = 0; i < 14; i++) run_vec(0, tbl[i], $sformatf("sat%0d", i));
        check("sat pre", ops_done, CntMax - 1);
        for (int i = 0; i < 3; i++) begin
            run_vec(1, tbl[i], $sformatf("satx%0d", i));
            check("sat hold", ops_done, CntMax);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rr_sched.md
ALU_RR_SCHED -- requirements
Module: alu_rr_sched

Interface
REQ-001 SHALL have parameter DW, default 8, datapath width in bits for operands and results.
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 reqN_valid_i  input  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready_o  output  1  scheduler accepts requester N's operation this cycle.
REQ-007 reqN_a_i, reqN_b_i  input  DW each  requester N operands.
REQ-008 reqN_op_i  input  3  requester N opcode.
REQ-009 rspN_valid_o  output  1  result for requester N is available.
REQ-010 rspN_ready_i  input  1  requester N consumes its result.
REQ-011 rspN_data_o  output  DW  result for requester N.
REQ-012 busy_o  output  1  high whenever the FSM is not IDLE.
REQ-013 ops_done_o  output  CNT_W  count of completed response handshakes.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; one operation in flight at a time.
REQ-015 IDLE: if any reqN_valid_i, grant one requester, assert only its reqN_ready_o and capture a, b, op, and owner ID; next state EXEC.
REQ-016 Arbitration SHALL be round-robin: pointer prio selects the winner when both are valid; a lone valid requester always wins.
REQ-017 After any grant, prio SHALL point to the non-granted requester; prio resets to 0.
REQ-018 reqN_ready_o SHALL be low in EXEC and RESP; ready may depend on valids, but requesters must not make valid depend on ready.
REQ-019 EXEC: register the ALU result into the result register; next state RESP.
REQ-020 RESP: assert rspN_valid_o for the owner only, with rspN_data_o from the result register; on rspN_ready_i go to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from the request handshake edge to rspN_valid_o high.
REQ-022 With an immediate response handshake, one operation SHALL complete every 3 cycles.
REQ-023 rspN_valid_o and rspN_data_o SHALL stay stable while valid is high and ready is low.
REQ-024 rspN_ready_i SHALL be ignored when rspN_valid_o is low.
REQ-025 ALU ops: 000 a+b, 001 a-b, 010 a<<b, 011 a>>b, 100 a&b, 101 a|b, 110 ~(a^b), 111 zero-extended (a==b).
REQ-026 Add and subtract SHALL wrap modulo 2^DW; shifts are logical; a shift amount >= DW yields 0.
REQ-027 ops_done_o SHALL increment by 1 on each response handshake and saturate at all-ones.
REQ-028 busy_o SHALL equal (state != IDLE).

Reset
REQ-029 Asserting rst_ni low at any time, including mid-operation, SHALL immediately force: state IDLE, prio 0, operand and result registers 0, ops_done_o 0.
REQ-030 During reset, all reqN_ready_o, rspN_valid_o and busy_o SHALL be 0 and rspN_data_o SHALL be 0; an in-flight operation is discarded.
REQ-031 Reset deassertion SHALL be synchronized externally; the first cycle after reset SHALL accept requests normally.

Structure
REQ-032 Package alu_sched_pkg SHALL hold the opcode enum (ADD, SUB, SHL, SHR, AND, OR, XNOR, EQ) and the FSM state enum.
REQ-033 Combinational ALU SHALL be a sub-module alu_core (DW-parameterised, inputs a, b, op; output y), instantiated once and shared by both requesters.

Verification
REQ-034 Reset, then req0 valid with a=8'h0F, b=8'h01, op=000 -> req0_ready_o high the same cycle; rsp0_valid_o high 2 cycles later with data 8'h10; rsp1_valid_o stays 0.
REQ-035 Both requesters valid back-to-back from reset (req0 op=001 a=8'h00 b=8'h01; req1 op=111 a=b=8'h5A) -> req0 served first with 8'hFF, then req1 with 8'h01; grants alternate 0,1,0,1 while both stay valid.
REQ-036 rsp0_ready_i held low for 5 cycles -> rsp0_data_o stable, both ready outputs low, no new grant; exactly one grant on the cycle after the handshake.
REQ-037 Shift check: op=010 a=8'h81 b=8'd1 -> 8'h02; op=011 a=8'h80 b=8'd9 -> 8'h00; op=110 a=8'hF0 b=8'h0F -> 8'h00.
REQ-038 rst_ni pulsed low during EXEC -> all outputs 0 asynchronously; no response is ever issued for that operation; ops_done_o reads 0.
REQ-039 Force ops_done_o to all-ones minus 1, then complete 3 operations -> counter reads all-ones and holds.
